// File: rtl/vram_pkg.sv
// Shared definitions for the text VRAM writer/reader pair: bus widths, line origin,
// ASCII control codes and the reader FSM encoding.
package vram_pkg;

    localparam int VRAM_AW = 11;
    localparam int VRAM_DW = 8;

    localparam logic [VRAM_AW-1:0] TEXT_BASE = 11'd120;

    localparam logic [VRAM_DW-1:0] BS  = 8'h08;
    localparam logic [VRAM_DW-1:0] CR  = 8'h0D;
    localparam logic [VRAM_DW-1:0] NUL = 8'h00;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE   = 2'd0;
    localparam rd_state_t ST_FETCH  = 2'd1;
    localparam rd_state_t ST_DRAIN  = 2'd2;
    localparam rd_state_t ST_FINISH = 2'd3;

    typedef struct packed {
        logic                last;
        logic [VRAM_DW-1:0]  data;
    } fifo_entry_t;

endpackage

// File: rtl/vram_text_reader_if.sv
// Control, VRAM read port and byte-stream signals of the text line reader.
// master is the reader itself; slave is the surrounding logic and VRAM.
interface vram_text_reader_if;
    import vram_pkg::*;

    logic               start;
    logic [VRAM_AW-1:0] end_addr;
    logic [VRAM_AW-1:0] vaddr;
    logic [VRAM_DW-1:0] vdata;
    logic [VRAM_DW-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               done;
    logic [VRAM_AW-1:0] byte_count;

    modport master (
        input  start, end_addr, vdata, out_ready,
        output vaddr, out_data, out_valid, out_last, busy, done, byte_count
    );

    modport slave (
        output start, end_addr, vdata, out_ready,
        input  vaddr, out_data, out_valid, out_last, busy, done, byte_count
    );

endinterface

// File: rtl/vram_text_reader_byte_skid_fifo.sv
// Small circular buffer of {last, data} entries absorbing VRAM reads while the
// consumer stalls. Caller guarantees no push when full and no pop when empty.
module byte_skid_fifo
    import vram_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    input  logic          pop,
    output fifo_entry_t   head,
    output logic [CW-1:0] count
);

    fifo_entry_t   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{last: 1'b0, data: 8'h00};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/vram_text_reader.sv
// Streams the typed text line (BASE_ADDR up to the latched cursor, exclusive) out of
// the text VRAM over a valid/ready byte interface; read-only user of one VRAM port.
module vram_text_reader
    import vram_pkg::*;
#(
    parameter logic [VRAM_AW-1:0] BASE_ADDR = TEXT_BASE,
    parameter int                 RD_LAT    = 1
) (
    input logic                clk,
    input logic                rst,
    vram_text_reader_if.master bus
);

    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    rd_state_t          state_r;
    logic [VRAM_AW-1:0] end_r;
    logic [VRAM_AW-1:0] vaddr_r;
    logic [VRAM_AW-1:0] byte_count_r;
    logic               busy_r;
    logic               done_r;
    logic [CW-1:0]      inflight_r;
    logic [RD_LAT-1:0]  tag_vld_r;
    logic [RD_LAT-1:0]  tag_last_r;

    logic               issue_s;
    logic               last_issue_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_valid_s;
    logic [CW:0]        occ_s;
    logic [CW-1:0]      fifo_count_s;
    fifo_entry_t        push_entry_s;
    fifo_entry_t        head_s;

    // Credit check: a byte leaving the FIFO this cycle frees its slot for a new issue,
    // which is what sustains one byte per cycle with a depth of only RD_LAT+1.
    always_comb begin
        fifo_valid_s      = (fifo_count_s != {CW{1'b0}});
        pop_s             = fifo_valid_s & bus.out_ready;
        push_s            = tag_vld_r[RD_LAT-1];
        push_entry_s.last = tag_last_r[RD_LAT-1];
        push_entry_s.data = bus.vdata;
        occ_s             = {1'b0, inflight_r} + {1'b0, fifo_count_s} - {{CW{1'b0}}, pop_s};
        issue_s           = (state_r == ST_FETCH) && (occ_s < (CW + 1)'(FIFO_DEPTH));
        last_issue_s      = issue_s && (vaddr_r == end_r - 11'd1);
    end

    byte_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (fifo_count_s)
    );

    // Read-latency tag pipe and count of reads whose data has not yet reached the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r  <= {RD_LAT{1'b0}};
            tag_last_r <= {RD_LAT{1'b0}};
            inflight_r <= {CW{1'b0}};
        end else begin
            tag_vld_r  <= (tag_vld_r << 1) | RD_LAT'(issue_s);
            tag_last_r <= (tag_last_r << 1) | RD_LAT'(last_issue_s);
            inflight_r <= inflight_r + CW'(issue_s) - CW'(push_s);
        end
    end

    // Line read sequencer; an empty line goes straight to FINISH without touching VRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            end_r        <= BASE_ADDR;
            vaddr_r      <= BASE_ADDR;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            byte_count_r <= 11'd0;
        end else begin
            done_r <= 1'b0;
            if (pop_s) begin
                byte_count_r <= byte_count_r + 11'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        end_r        <= bus.end_addr;
                        byte_count_r <= 11'd0;
                        if (bus.end_addr <= BASE_ADDR) begin
                            state_r <= ST_FINISH;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_s) begin
                        vaddr_r <= vaddr_r + 11'd1;
                        if (last_issue_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_r == {CW{1'b0}}) && !fifo_valid_s) begin
                        state_r <= ST_FINISH;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        vaddr_r <= BASE_ADDR;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    vaddr_r <= BASE_ADDR;
                end
            endcase
        end
    end

    assign bus.vaddr      = vaddr_r;
    assign bus.out_valid  = fifo_valid_s;
    assign bus.out_data   = head_s.data;
    assign bus.out_last   = fifo_valid_s & head_s.last;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.byte_count = byte_count_r;

endmodule
